// File: rtl/mem_dump_streamer_if.sv
// Bus bundle for mem_dump_streamer: dump command, memory read port and output stream.
// master = the streamer; slave = the surrounding controller / memory / consumer.
interface mem_dump_streamer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, base_addr, count, mem_rdata, out_ready,
    output mem_addr, mem_re, out_data, out_valid, busy, done
  );

  modport slave (
    output start, base_addr, count, mem_rdata, out_ready,
    input  mem_addr, mem_re, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/mem_dump_streamer.sv
// Streams count consecutive memory words starting at base_addr, one read in flight at a time,
// through a valid/ready output register. All outputs are registered.
module mem_dump_streamer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input logic                clk,
  input logic                reset,
  mem_dump_streamer_if.master bus
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, SHOW, DONE} state_t;

  state_t          state;
  logic [ADDR_W:0] remaining;
  // vld_pipe[k] high k cycles after the read strobe; top bit marks the cycle rdata is valid
  logic [RD_LAT:0] vld_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      remaining     <= '0;
      vld_pipe      <= '0;
      bus.mem_addr  <= '0;
      bus.mem_re    <= 1'b0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.mem_re <= 1'b0;
      bus.done   <= 1'b0;
      vld_pipe   <= {vld_pipe[RD_LAT-1:0], 1'b0};
      case (state)
        IDLE: begin
          if (bus.start) begin
            remaining <= bus.count;
            bus.busy  <= 1'b1;
            if (bus.count != '0) begin
              bus.mem_addr <= bus.base_addr;
              bus.mem_re   <= 1'b1;
              vld_pipe[0]  <= 1'b1;
              state        <= READ;
            end else begin
              bus.done <= 1'b1;
              state    <= DONE;
            end
          end
        end
        READ: state <= WAIT;
        WAIT: begin
          if (vld_pipe[RD_LAT]) begin
            bus.out_data  <= bus.mem_rdata;
            bus.out_valid <= 1'b1;
            state         <= SHOW;
          end
        end
        SHOW: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            remaining     <= remaining - 1'b1;
            if (remaining == (ADDR_W+1)'(1)) begin
              bus.done <= 1'b1;
              state    <= DONE;
            end else begin
              // natural modulo-2^ADDR_W wrap of the address register
              bus.mem_addr <= bus.mem_addr + 1'b1;
              bus.mem_re   <= 1'b1;
              vld_pipe[0]  <= 1'b1;
              state        <= READ;
            end
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
